// File: rtl/fft_axi_responder.sv
// Memory-side responder for the FFT core: streams preloaded samples as read bursts
// and collects result beats into a host-readable result buffer.
module fft_axi_responder #(
    parameter int N  = 4,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [31:0]   ARDATA,
    output logic          ARVALID,
    input  logic          ARREADY,
    input  logic [N:0]    ARBURST,
    input  logic [32:0]   AWDATA,
    input  logic          AWVALID,
    output logic          AWREADY,
    input  logic [N:0]    AWBURST,
    input  logic [11:0]   SAMP_NUMBER,
    input  logic          start,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic          perr
);
    localparam int LW      = AW + 1;
    localparam int CW      = (12 > LW) ? 12 : LW;
    localparam int DEPTH_I = 1 << AW;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH_I);
    localparam logic [LW-1:0] ZERO_L  = {LW{1'b0}};
    localparam logic [LW-1:0] ONE_L   = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [N:0]    ZERO_N  = {(N+1){1'b0}};
    localparam logic [N:0]    ONE_N   = {{N{1'b0}}, 1'b1};

    typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_BURST = 2'd1, RD_END = 2'd2} rd_state_t;
    typedef enum logic {WR_IDLE = 1'b0, WR_BURST = 1'b1} wr_state_t;

    logic [31:0] samp_mem [0:DEPTH_I-1];
    logic [31:0] res_mem  [0:DEPTH_I-1];

    rd_state_t     rd_state_q, rd_state_d;
    wr_state_t     wr_state_q, wr_state_d;
    logic [LW-1:0] len_frame_q, len_frame_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [N:0]    rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [N:0]    wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic          busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, perr_q, perr_d;

    logic          start_ok_s, wr_beat_s, wr_last_s, wr_fill_s;
    logic [CW-1:0] samp_c_s;
    logic [LW-1:0] frame_len_s, rd_rem_s;
    logic [N:0]    wr_cur_len_s, wr_cnt_next_s;

    assign ARVALID = (rd_state_q == RD_BURST);
    assign ARDATA  = ARVALID ? samp_mem[rd_ptr_q[AW-1:0]] : 32'd0;
    assign AWREADY = busy_q && (wr_ptr_q < len_frame_q);
    assign rd_data = res_mem[rd_addr];
    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;
    assign perr    = perr_q;

    // Frame length clamp and write-burst bookkeeping derived from current state.
    always_comb begin
        start_ok_s  = start && !busy_q;
        samp_c_s    = CW'(SAMP_NUMBER);
        frame_len_s = (samp_c_s > DEPTH_C) ? DEPTH_C[LW-1:0] : samp_c_s[LW-1:0];
        rd_rem_s    = len_frame_q - rd_ptr_q;
        wr_beat_s   = AWVALID && AWREADY;
        if (wr_state_q == WR_IDLE) begin
            wr_cur_len_s  = (AWBURST == ZERO_N) ? ONE_N : AWBURST;
            wr_cnt_next_s = ONE_N;
        end else begin
            wr_cur_len_s  = wlen_q;
            wr_cnt_next_s = wcnt_q + ONE_N;
        end
        wr_fill_s = ((wr_ptr_q + ONE_L) == len_frame_q);
        wr_last_s = (wr_cnt_next_s == wr_cur_len_s) || wr_fill_s;
    end

    // Read-channel FSM: burst sizing, pointer advance and end-of-frame parking.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_ptr_d   = rd_ptr_q;
        rlen_d     = rlen_q;
        rcnt_d     = rcnt_q;
        if (start_ok_s) begin
            rd_state_d = RD_IDLE;
            rd_ptr_d   = ZERO_L;
            rcnt_d     = ZERO_N;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (busy_q && (rd_ptr_q < len_frame_q) && ARREADY && (ARBURST != ZERO_N)) begin
                        rlen_d     = (32'(ARBURST) > 32'(rd_rem_s)) ? rd_rem_s[N:0] : ARBURST;
                        rcnt_d     = ZERO_N;
                        rd_state_d = RD_BURST;
                    end else begin
                        rd_state_d = RD_IDLE;
                    end
                end
                RD_BURST: begin
                    if (ARREADY) begin
                        rd_ptr_d = rd_ptr_q + ONE_L;
                        rcnt_d   = rcnt_q + ONE_N;
                        if (rcnt_d == rlen_q) begin
                            rd_state_d = (rd_ptr_d == len_frame_q) ? RD_END : RD_IDLE;
                        end else begin
                            rd_state_d = RD_BURST;
                        end
                    end else begin
                        rd_state_d = RD_BURST;
                    end
                end
                RD_END:  rd_state_d = RD_END;
                default: rd_state_d = RD_IDLE;
            endcase
        end
    end

    // Write-channel FSM: burst length capture on first beat, pointer advance.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_ptr_d   = wr_ptr_q;
        wlen_d     = wlen_q;
        wcnt_d     = wcnt_q;
        if (start_ok_s) begin
            wr_state_d = WR_IDLE;
            wr_ptr_d   = ZERO_L;
            wcnt_d     = ZERO_N;
        end else if (wr_beat_s) begin
            wr_ptr_d   = wr_ptr_q + ONE_L;
            wlen_d     = wr_cur_len_s;
            wcnt_d     = wr_last_s ? ZERO_N : wr_cnt_next_s;
            wr_state_d = wr_last_s ? WR_IDLE : WR_BURST;
        end else begin
            wr_state_d = wr_state_q;
        end
    end

    // Frame control and sticky status flags.
    always_comb begin
        len_frame_d = len_frame_q;
        busy_d      = busy_q;
        done_d      = done_q;
        ovf_d       = ovf_q;
        perr_d      = perr_q;
        if (start_ok_s) begin
            len_frame_d = frame_len_s;
            busy_d      = (frame_len_s != ZERO_L);
            done_d      = (frame_len_s == ZERO_L);
            ovf_d       = 1'b0;
            perr_d      = 1'b0;
        end else begin
            if (wr_beat_s && wr_fill_s) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = busy_q;
            end
            if (wr_beat_s && (AWDATA[32] != wr_last_s)) begin
                perr_d = 1'b1;
            end else begin
                perr_d = perr_q;
            end
            if (AWVALID && !busy_q && done_q) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q  <= RD_IDLE;
            wr_state_q  <= WR_IDLE;
            len_frame_q <= ZERO_L;
            rd_ptr_q    <= ZERO_L;
            wr_ptr_q    <= ZERO_L;
            rlen_q      <= ZERO_N;
            rcnt_q      <= ZERO_N;
            wlen_q      <= ZERO_N;
            wcnt_q      <= ZERO_N;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            rd_state_q  <= rd_state_d;
            wr_state_q  <= wr_state_d;
            len_frame_q <= len_frame_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rlen_q      <= rlen_d;
            rcnt_q      <= rcnt_d;
            wlen_q      <= wlen_d;
            wcnt_q      <= wcnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            perr_q      <= perr_d;
        end
    end

    // Buffers survive reset; host loads are locked out during a frame.
    always_ff @(posedge clk) begin
        if (ld_we && !busy_q) begin
            samp_mem[ld_addr] <= ld_data;
        end
        if (wr_beat_s) begin
            res_mem[wr_ptr_q[AW-1:0]] <= AWDATA[31:0];
        end
    end

endmodule

// File: tb/tb_fft_axi_responder.sv
// Randomized bench for fft_axi_responder: transaction-level reference of the read
// stream, burst sizes, result buffer and status flags.
module tb_fft_axi_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ARDATA;
    logic        ARVALID;
    logic        ARREADY;
    logic [4:0]  ARBURST;
    logic [32:0] AWDATA;
    logic        AWVALID;
    logic        AWREADY;
    logic [4:0]  AWBURST;
    logic [11:0] SAMP_NUMBER;
    logic        start;
    logic        ld_we;
    logic [11:0] ld_addr;
    logic [31:0] ld_data;
    logic [11:0] rd_addr;
    logic [31:0] rd_data;
    logic        busy, done, ovf, perr;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        rd_done;
    logic [31:0] samp_m [0:63];
    logic [31:0] res_m  [0:63];

    fft_axi_responder #(.N(4), .AW(12)) dut (
        .clk(clk), .rst_n(rst_n), .ARDATA(ARDATA), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .ARBURST(ARBURST), .AWDATA(AWDATA), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .AWBURST(AWBURST), .SAMP_NUMBER(SAMP_NUMBER), .start(start), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .ovf(ovf), .perr(perr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read side: every accepted beat must be the next sample; bursts sized min(ARBURST, remaining).
    task automatic reader(input int L, input int arb, input int mode);
        int   exp_b[$];
        int   rem = L;
        int   beats = 0, cur = 0, bi = 0, cyc = 0;
        logic pv = 1'b0, pr = 1'b0;
        logic [31:0] pd = 32'd0;
        while (rem > 0) begin
            int b = (rem < arb) ? rem : arb;
            exp_b.push_back(b);
            rem -= b;
        end
        ARBURST = 5'(arb);
        while ((beats < L || cur > 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            ld_we = (cyc == 1);
            ld_addr = 12'(L - 1);
            ld_data = ~samp_m[L-1];
            if (pv && !pr) begin
                check_eq("ar_hold_valid", ARVALID, 1);
                check_eq("ar_hold_data", ARDATA, pd);
            end
            if (!ARVALID && cur > 0) begin
                check_eq("ar_burst_len", cur, (bi < exp_b.size()) ? exp_b[bi] : 0);
                bi++;
                cur = 0;
            end
            case (mode)
                0:       ARREADY = 1'b1;
                1:       ARREADY = (cyc % 2 == 1);
                default: ARREADY = 1'($urandom_range(0, 1));
            endcase
            if (ARVALID && ARREADY) begin
                check_eq("ar_data", ARDATA, (beats < L) ? samp_m[beats] : 32'hDEAD_BEEF);
                beats++;
                cur++;
            end
            pv = ARVALID;
            pr = ARREADY;
            pd = ARDATA;
        end
        ld_we = 1'b0;
        if (cyc >= 4000) check_eq("ar_timeout", 0, 1);
        check_eq("ar_bursts", bi, exp_b.size());
        ARREADY = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("ar_idle_after", ARVALID, 0);
        end
        ARREADY = 1'b0;
        rd_done = 1'b1;
    endtask

    // Write side: marker bit is set on burst ends (per AWBURST, 0 => 1) and frame end, xor a planted error.
    task automatic writer(input int L, input int awb, input int bad);
        int j = 0;
        int wl = (awb == 0) ? 1 : awb;
        AWBURST = 5'(awb);
        for (int i = 0; i < L; i++) begin
            logic        last;
            logic [31:0] d = $urandom;
            int          w = 0;
            j++;
            last = (j == wl) || (i == L - 1);
            if (last) j = 0;
            res_m[i] = d;
            if (i == L - 1) begin
                while (!rd_done && w < 5000) begin @(negedge clk); w++; end
                if (w >= 5000) check_eq("rd_done_timeout", 0, 1);
                w = 0;
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            AWVALID = 1'b1;
            AWDATA = {last ^ (i == bad), d};
            while (!AWREADY && w < 200) begin @(negedge clk); w++; end
            if (w >= 200) begin
                check_eq("aw_ready_timeout", 0, 1);
                AWVALID = 1'b0;
                break;
            end
            @(negedge clk);
            AWVALID = 1'b0;
        end
    endtask

    task automatic run_frame(input int L, input int arb, input int mode, input int awb, input int bad);
        @(negedge clk);
        SAMP_NUMBER = 12'(L);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_busy", busy, 1);
        check_eq("start_done", done, 0);
        rd_done = 1'b0;
        fork
            reader(L, arb, mode);
            writer(L, awb, bad);
        join
        check_eq("end_busy", busy, 0);
        check_eq("end_done", done, 1);
        check_eq("end_awready", AWREADY, 0);
        check_eq("end_perr", perr, (bad >= 0 && bad < L) ? 1 : 0);
        check_eq("end_ovf", ovf, 0);
        for (int i = 0; i < L; i++) begin
            rd_addr = 12'(i);
            #1;
            check_eq("rd_data", rd_data, res_m[i]);
        end
    endtask

    initial begin
        int w;
        rst_n = 1'b0; ARREADY = 1'b0; ARBURST = 5'd0; AWDATA = 33'd0; AWVALID = 1'b0;
        AWBURST = 5'd0; SAMP_NUMBER = 12'd0; start = 1'b0; ld_we = 1'b0; ld_addr = 12'd0;
        ld_data = 32'd0; rd_addr = 12'd0; rd_done = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_arvalid", ARVALID, 0);
        check_eq("rst_ardata", ARDATA, 0);
        check_eq("rst_awready", AWREADY, 0);
        check_eq("rst_flags", {busy, done, ovf, perr}, 0);
        rst_n = 1'b1;

        for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            samp_m[a] = (a < 16) ? 32'(a * 3) : $urandom;
            ld_we = 1'b1; ld_addr = 12'(a); ld_data = samp_m[a];
        end
        @(negedge clk);
        ld_we = 1'b0;

        run_frame(16, 4, 0, 8, -1);
        run_frame(16, 5, 1, 8, 2);
        @(negedge clk);
        AWVALID = 1'b1;
        check_eq("ovf_awready", AWREADY, 0);
        @(negedge clk);
        AWVALID = 1'b0;
        check_eq("ovf_flag", ovf, 1);
        check_eq("ovf_done", done, 1);
        run_frame(10, 4, 2, 3, -1);
        run_frame(7, 31, 1, 0, -1);

        @(negedge clk);
        SAMP_NUMBER = 12'd16; start = 1'b1; ARBURST = 5'd4; ARREADY = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!ARVALID && w < 20) begin @(negedge clk); w++; end
        check_eq("rst_mid_burst_started", ARVALID, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_arvalid", ARVALID, 0);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_awready", AWREADY, 0);
        ARREADY = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(16, 4, 0, 8, -1);

        @(negedge clk);
        SAMP_NUMBER = 12'd0; start = 1'b1; ARREADY = 1'b1; ARBURST = 5'd4;
        @(negedge clk);
        start = 1'b0;
        check_eq("zero_done", done, 1);
        check_eq("zero_busy", busy, 0);
        repeat (3) begin
            @(negedge clk);
            check_eq("zero_arvalid", ARVALID, 0);
            check_eq("zero_awready", AWREADY, 0);
        end
        ARREADY = 1'b0;

        for (int k = 0; k < 4; k++) begin
            int L = $urandom_range(1, 40);
            int bad = ($urandom_range(0, 1) == 1) ? $urandom_range(0, L - 1) : -1;
            run_frame(L, $urandom_range(1, 31), $urandom_range(0, 2), $urandom_range(0, 31), bad);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fft_axi_responder.md
Name: fft_axi_responder

Overview:
- Memory-side responder for the FFT core's sample/result bus.
- Read channel: serves time-domain samples from an internal sample buffer as bursts on ARDATA/ARVALID, paced by ARREADY and the core-requested ARBURST length.
- Write channel: accepts results on AWDATA/AWVALID with AWREADY backpressure and stores them in a result buffer.
- Used as the testbench/system-side endpoint in front of the FFT top level; a host preloads samples and reads results back through side ports.

Parameters:
N, 4, burst-length field width is N+1 bits; maximum burst is 2^(N+1)-1 beats
AW, 12, buffer address width; each buffer holds 2^AW words

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
ARDATA  output  32  sample beat to FFT core
ARVALID  output  1  ARDATA valid
ARREADY  input  1  core accepts beat; also core-ready-for-burst
ARBURST  input  N+1  requested read burst length, sampled at burst start
AWDATA  input  33  [31:0] result word, [32] last-beat marker
AWVALID  input  1  AWDATA valid
AWREADY  output  1  responder accepts write beat
AWBURST  input  N+1  write burst length, sampled on first beat of burst
SAMP_NUMBER  input  12  samples per frame, sampled on start
start  input  1  one-cycle pulse, begins a frame
ld_we  input  1  host sample-buffer write strobe
ld_addr  input  AW  host sample-buffer address
ld_data  input  32  host sample word
rd_addr  input  AW  host result-buffer address
rd_data  output  32  result word at rd_addr, combinational read
busy  output  1  frame in progress
done  output  1  sticky, all SAMP_NUMBER results received
ovf  output  1  sticky, write beat offered after frame complete
perr  output  1  sticky, AWDATA[32] inconsistent with burst end

Behaviour:
- Reset: ARVALID=0, AWREADY=0, busy=0, done=0, ovf=0, perr=0, ARDATA=0, all pointers/counters 0, both FSMs IDLE. Buffer contents not cleared. Reset mid-frame aborts immediately.
- Beat transfers: read when ARVALID&&ARREADY; write when AWVALID&&AWREADY, at the rising edge.
- start while busy=0: latch SAMP_NUMBER as frame length L, clear rd_ptr/wr_ptr/done/ovf/perr, busy=1 next cycle. start while busy=1 ignored. L=0: no transfers; done=1, busy=0 on cycle after start.
- ld_we ignored while busy=1; otherwise writes ld_data at ld_addr.
- Read FSM RD_IDLE/RD_BURST/RD_END:
  - RD_IDLE, busy=1, rd_ptr<L, ARREADY=1, ARBURST!=0: latch len=min(ARBURST, L-rd_ptr), go RD_BURST.
  - RD_IDLE, ARBURST=0: stay.
  - RD_BURST: ARVALID=1; ARDATA=sample[rd_ptr] (combinational buffer read, registered output not required). Each read beat: rd_ptr+1, count+1.
  - count==len after beat: ARVALID=0 next cycle. Then RD_END if rd_ptr==L, else RD_IDLE.
  - ARVALID/ARDATA hold stable while ARREADY=0. Back-to-back beats at one per cycle.
  - Minimum one idle cycle between bursts.
  - RD_END: ARVALID=0 until next start.
- Write FSM WR_IDLE/WR_BURST:
  - AWREADY=1 whenever busy=1 and wr_ptr<L.
  - First accepted beat in WR_IDLE latches wlen=AWBURST (0 treated as 1), enter WR_BURST. Each write beat: result[wr_ptr]=AWDATA[31:0], wr_ptr+1, wcount+1.
  - Beat completing wlen, or making wr_ptr==L, ends burst -> WR_IDLE. AWDATA[32] must be 1 exactly on that beat; any mismatch sets perr, data still stored.
  - wr_ptr==L after beat: AWREADY=0, done=1, busy=0 next cycle.
- AWVALID=1 with busy=0 after a completed frame: AWREADY stays 0, ovf=1.
- Read and write channels independent; simultaneous beats on both in one cycle allowed.
- Pointers never wrap; L>2^AW clamped to 2^AW.

Test Plan:
- Load samples 0..15 as value=addr*3, SAMP_NUMBER=16, start, ARBURST=4, ARREADY=1 -> four bursts of 4 beats, ARDATA 0,3,...,45 in order, one gap cycle between bursts.
- ARREADY toggling 1/0 each cycle mid-burst -> ARDATA/ARVALID stable during low cycles, no beat lost or repeated.
- SAMP_NUMBER=10, ARBURST=4 -> bursts of 4,4,2, then ARVALID stays 0.
- Write 16 results in bursts of 8, AWDATA[32]=1 on beats 8 and 16 -> result buffer matches, done=1, busy=0, perr=0.
- AWDATA[32]=1 on beat 3 of an 8-beat burst -> perr=1. Extra AWVALID after done -> AWREADY=0, ovf=1.
- rst_n low mid-read-burst -> ARVALID=0, busy=0 immediately. New start resends from sample 0. SAMP_NUMBER=0 start -> done=1 next cycle, no beats.
